// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, trace entry type and lane-merge helper for dmem_responder
package dmem_pkg;

  localparam logic [31:0] DMEM_TOHOST_ADDR = 32'd100;
  localparam logic [31:0] DMEM_PASS_VALUE  = 32'd25;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } dmem_trace_t;

  // Byte lane i of the result comes from new_word when be[i] is set, else from old_word.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (new_word & mask) | (old_word & ~mask);
  endfunction

endpackage

// File: rtl/dmem_trace_fifo.sv
// rtl/dmem_trace_fifo.sv - first-word-fall-through FIFO of dmem_trace_t store records
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   push/push_data write request and entry
//   pop            consumer take; ignored while empty
//   head           head entry, zero while empty
//   valid/empty    FIFO holds at least one entry / holds none
//   full           all DEPTH slots in use
//   overflow       sticky: a push was dropped because the FIFO was full
module dmem_trace_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  dmem_trace_t push_data,
  input  logic        pop,
  output dmem_trace_t head,
  output logic        valid,
  output logic        full,
  output logic        empty,
  output logic        overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  dmem_trace_t      store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             ovf_q;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign valid   = !empty;
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push && !do_push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  // Storage is not reset, so the head is masked to read as zero when empty.
  assign head     = empty ? '0 : store[rd_ptr];
  assign overflow = ovf_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word RAM, tohost pass/fail decode, store trace
//
// Optional feature macro: DMEM_TRACE_EN (compiles in the store trace FIFO; otherwise trc_* read 0)
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   MemWrite/DataAdr/WriteData store strobe, byte address, store data
//   ByteEn                     store byte lane enables
//   ReadData                   combinational load data for DataAdr
//   done/pass                  sticky tohost completion and its pass status
//   addr_err                   sticky out-of-range access flag
//   trc_valid/addr/data/ready  trace head handshake
//   trc_overflow               sticky dropped-trace flag
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH       = 64,
  parameter logic [31:0] TOHOST_ADDR = DMEM_TOHOST_ADDR,
  parameter logic [31:0] PASS_VALUE  = DMEM_PASS_VALUE,
  parameter int          TRACE_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEn,
  output logic [31:0] ReadData,
  output logic        done,
  output logic        pass,
  output logic        addr_err,
  output logic        trc_valid,
  output logic [31:0] trc_addr,
  output logic [31:0] trc_data,
  input  logic        trc_ready,
  output logic        trc_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   ram [DEPTH];
  logic [31:0]   tohost_q;
  logic [29:0]   word_adr;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          is_tohost;
  logic [31:0]   old_word;
  logic [31:0]   merged;
  logic          unused_lsb;

  assign word_adr   = DataAdr[31:2];
  assign idx        = DataAdr[AW+1:2];
  assign in_range   = (word_adr < 30'(DEPTH));
  assign is_tohost  = (word_adr == TOHOST_ADDR[31:2]);
  assign unused_lsb = ^DataAdr[1:0];

  // The tohost word shadows RAM; out-of-range words read as zero, which also makes
  // the merged value of an out-of-range store equal WriteData masked by ByteEn.
  always_comb begin
    old_word = '0;
    if (is_tohost)     old_word = tohost_q;
    else if (in_range) old_word = ram[idx];
  end

  assign ReadData = old_word;
  assign merged   = lane_merge(old_word, WriteData, ByteEn);

  // A store on an edge where reset is held low is discarded.
  always_ff @(posedge clk) begin
    if (reset && MemWrite && in_range && !is_tohost) ram[idx] <= merged;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tohost_q <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      // There is no load strobe, so any edge that sees an out-of-range address counts.
      if (!in_range && !is_tohost) addr_err <= 1'b1;
      if (MemWrite && is_tohost) begin
        tohost_q <= merged;
        done     <= 1'b1;
        pass     <= (merged == PASS_VALUE);
      end
    end
  end

`ifdef DMEM_TRACE_EN
  dmem_trace_t trc_push_data;
  dmem_trace_t trc_head;
  logic        trc_full_unused;
  logic        trc_empty_unused;

  assign trc_push_data = '{addr: {word_adr, 2'b00}, data: merged};

  dmem_trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (MemWrite),
    .push_data (trc_push_data),
    .pop       (trc_ready),
    .head      (trc_head),
    .valid     (trc_valid),
    .full      (trc_full_unused),
    .empty     (trc_empty_unused),
    .overflow  (trc_overflow)
  );

  assign trc_addr = trc_head.addr;
  assign trc_data = trc_head.data;
`else
  logic unused_trc_ready;

  assign unused_trc_ready = trc_ready;
  assign trc_valid        = 1'b0;
  assign trc_addr         = '0;
  assign trc_data         = '0;
  assign trc_overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder against a queue model
module tb_dmem_responder;

  localparam int          DEPTH  = 64;
  localparam int          TD     = 8;
  localparam logic [31:0] TOHOST = 32'd100;
  localparam logic [31:0] PASSV  = 32'd25;
`ifdef DMEM_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  logic        clk, reset, MemWrite, trc_ready;
  logic [31:0] DataAdr, WriteData, ReadData, trc_addr, trc_data;
  logic [3:0]  ByteEn;
  logic        done, pass, addr_err, trc_valid, trc_overflow;

  dmem_responder #(
    .DEPTH(DEPTH), .TOHOST_ADDR(TOHOST), .PASS_VALUE(PASSV), .TRACE_DEPTH(TD)
  ) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .ByteEn(ByteEn), .ReadData(ReadData),
    .done(done), .pass(pass), .addr_err(addr_err),
    .trc_valid(trc_valid), .trc_addr(trc_addr), .trc_data(trc_data),
    .trc_ready(trc_ready), .trc_overflow(trc_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_toh;
  bit          m_done, m_pass, m_err, m_ovf;
  ent_t        q[$];

  task automatic model_reset();
    m_toh = 0; m_done = 0; m_pass = 0; m_err = 0; m_ovf = 0;
    q.delete();
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] adr);
    if (adr[31:2] == TOHOST[31:2]) return m_toh;
    if (adr[31:2] < DEPTH)         return m_mem[adr[7:2]];
    return 32'd0;
  endfunction

  function automatic logic [31:0] head_a();
    return (q.size() > 0) ? q[0].a : 32'd0;
  endfunction

  function automatic logic [31:0] head_d();
    return (q.size() > 0) ? q[0].d : 32'd0;
  endfunction

  // Drive one cycle, let the edge happen, advance the model, settle 1 unit past the edge.
  task automatic cycle(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                       input logic [3:0] be, input bit rdy);
    logic [31:0] old, mg;
    bit inr, toh, popped;
    MemWrite = we; DataAdr = adr; WriteData = wd; ByteEn = be; trc_ready = rdy;
    @(posedge clk);
    inr = (adr[31:2] < DEPTH);
    toh = (adr[31:2] == TOHOST[31:2]);
    if (!inr && !toh) m_err = 1;
    popped = (q.size() > 0) && rdy;
    if (popped) void'(q.pop_front());
    if (we) begin
      old = m_read(adr);
      for (int b = 0; b < 4; b++) mg[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
      if (toh) begin
        m_toh = mg; m_done = 1; m_pass = (mg == PASSV);
      end else if (inr) begin
        m_mem[adr[7:2]] = mg;
      end
      if (TRACE) begin
        if (q.size() < TD) q.push_back('{a: {adr[31:2], 2'b00}, d: mg});
        else m_ovf = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    MemWrite = 0; DataAdr = TOHOST; WriteData = 0; ByteEn = 0; trc_ready = 0;
    reset = 0;
    model_reset();
    #21;
    checks += 7;
    if (done !== 1'b0)         begin errors++; $display("FAIL rst_done got %b want 0", done); end
    if (pass !== 1'b0)         begin errors++; $display("FAIL rst_pass got %b want 0", pass); end
    if (addr_err !== 1'b0)     begin errors++; $display("FAIL rst_addr_err got %b want 0", addr_err); end
    if (trc_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", trc_overflow); end
    if (trc_valid !== 1'b0)    begin errors++; $display("FAIL rst_valid got %b want 0", trc_valid); end
    if ({trc_addr, trc_data} !== 64'd0) begin errors++; $display("FAIL rst_head got %h want 0", {trc_addr, trc_data}); end
    if (ReadData !== 32'd0)    begin errors++; $display("FAIL rst_tohost got %h want 0", ReadData); end
    #1 reset = 1;
  endtask

  task automatic test_tohost_pass();
    cycle(1, TOHOST, 32'd25, 4'hF, 0);
    checks += 5;
    if (done !== 1'b1) begin errors++; $display("FAIL pass_done got %b want 1", done); end
    if (pass !== 1'b1) begin errors++; $display("FAIL pass_pass got %b want 1", pass); end
    if (trc_valid !== (q.size() > 0)) begin errors++; $display("FAIL pass_valid got %b want %b", trc_valid, q.size() > 0); end
    if (trc_addr !== head_a() || trc_data !== head_d())
      begin errors++; $display("FAIL pass_head got %h/%h want %h/%h", trc_addr, trc_data, head_a(), head_d()); end
    if (ReadData !== 32'd25) begin errors++; $display("FAIL pass_load got %h want 19", ReadData); end
  endtask

  task automatic test_tohost_fail();
    cycle(1, 32'd96, 32'd7, 4'hF, 0);
    cycle(1, TOHOST, 32'd24, 4'hF, 0);
    DataAdr = 32'd96; MemWrite = 0; #1;
    checks += 3;
    if (ReadData !== 32'd7) begin errors++; $display("FAIL fail_ram24 got %h want 7", ReadData); end
    if (done !== 1'b1)      begin errors++; $display("FAIL fail_done got %b want 1", done); end
    if (pass !== 1'b0)      begin errors++; $display("FAIL fail_pass got %b want 0", pass); end
    for (int i = 0; i < 2*TD && q.size() > 0; i++) begin
      checks++;
      if (trc_valid !== 1'b1 || trc_addr !== q[0].a || trc_data !== q[0].d)
        begin errors++; $display("FAIL fail_drain got %b %h/%h want 1 %h/%h", trc_valid, trc_addr, trc_data, q[0].a, q[0].d); end
      cycle(0, 32'd96, 0, 0, 1);
    end
    checks++;
    if (trc_valid !== 1'b0) begin errors++; $display("FAIL fail_empty got %b want 0", trc_valid); end
  endtask

  task automatic test_lane_merge();
    cycle(1, 32'd0, 32'hAABBCCDD, 4'hF, 1);
    cycle(1, 32'd0, 32'h11223344, 4'b0101, 1);
    checks += 3;
    if (ReadData !== 32'hAA22CC44) begin errors++; $display("FAIL lane_load got %h want aa22cc44", ReadData); end
    if (trc_valid !== (q.size() > 0)) begin errors++; $display("FAIL lane_valid got %b want %b", trc_valid, q.size() > 0); end
    if (trc_addr !== head_a() || trc_data !== head_d())
      begin errors++; $display("FAIL lane_head got %h/%h want %h/%h", trc_addr, trc_data, head_a(), head_d()); end
    cycle(0, 32'd0, 0, 0, 1);
    checks++;
    if (trc_valid !== 1'b0) begin errors++; $display("FAIL lane_empty got %b want 0", trc_valid); end
  endtask

  task automatic test_overflow();
    int w, seen;
    logic [31:0] last_a, last_d;
    checks++;
    if (trc_overflow !== 1'b0) begin errors++; $display("FAIL ovf_pre got %b want 0", trc_overflow); end
    for (int i = 0; i < TD + 1; i++) begin
      do w = $urandom_range(0, DEPTH-1); while (w == TOHOST[31:2]);
      cycle(1, 32'(w*4), $urandom, 4'hF, 0);
    end
    checks += 3;
    if (trc_overflow !== m_ovf) begin errors++; $display("FAIL ovf_set got %b want %b", trc_overflow, m_ovf); end
    if (trc_valid !== (q.size() > 0)) begin errors++; $display("FAIL ovf_valid got %b want %b", trc_valid, q.size() > 0); end
    if (trc_addr !== head_a() || trc_data !== head_d())
      begin errors++; $display("FAIL ovf_head got %h/%h want %h/%h", trc_addr, trc_data, head_a(), head_d()); end
    // Full, pop and push on the same edge: push must be accepted and come out last.
    cycle(1, 32'd12, 32'hCAFEF00D, 4'hF, 1);
    seen = 0; last_a = 0; last_d = 0;
    for (int i = 0; i < 2*TD && q.size() > 0; i++) begin
      checks++;
      if (trc_valid !== 1'b1 || trc_addr !== q[0].a || trc_data !== q[0].d)
        begin errors++; $display("FAIL ovf_drain got %b %h/%h want 1 %h/%h", trc_valid, trc_addr, trc_data, q[0].a, q[0].d); end
      last_a = trc_addr; last_d = trc_data; seen++;
      cycle(0, 32'd12, 0, 0, 1);
    end
    checks += 3;
    if (seen != (TRACE ? TD : 0)) begin errors++; $display("FAIL ovf_count got %0d want %0d", seen, TRACE ? TD : 0); end
    if (TRACE && {last_a, last_d} !== {32'd12, 32'hCAFEF00D})
      begin errors++; $display("FAIL ovf_last got %h/%h want c/cafef00d", last_a, last_d); end
    if (trc_overflow !== m_ovf) begin errors++; $display("FAIL ovf_hold got %b want %b", trc_overflow, m_ovf); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] wd, w0;
    logic [3:0]  be;
    wd = $urandom; be = 4'($urandom_range(1, 15));
    w0 = m_read(32'd0);
    cycle(1, 32'(4*DEPTH), wd, be, 1);
    checks += 3;
    if (ReadData !== 32'd0) begin errors++; $display("FAIL oor_load got %h want 0", ReadData); end
    if (addr_err !== 1'b1)  begin errors++; $display("FAIL oor_err got %b want 1", addr_err); end
    if (trc_addr !== head_a() || trc_data !== head_d())
      begin errors++; $display("FAIL oor_trace got %h/%h want %h/%h", trc_addr, trc_data, head_a(), head_d()); end
    DataAdr = 32'd0; MemWrite = 0; #1;
    checks++;
    if (ReadData !== w0) begin errors++; $display("FAIL oor_ram0 got %h want %h", ReadData, w0); end
    cycle(0, 32'd0, 0, 0, 1);
  endtask

  task automatic test_random();
    logic [31:0] adr;
    int r;
    for (int w = 0; w < DEPTH; w++)
      if (w != TOHOST[31:2]) cycle(1, 32'(w*4), $urandom, 4'hF, 1);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      adr = TOHOST | 32'($urandom_range(0, 3));
      else if (r == 1) adr = 32'(4*(DEPTH + $urandom_range(0, 200))) | 32'($urandom_range(0, 3));
      else             adr = 32'(4*$urandom_range(0, DEPTH-1)) | 32'($urandom_range(0, 3));
      cycle($urandom_range(0, 2) != 0, adr,
            (r == 0 && $urandom_range(0, 1) == 1) ? PASSV : $urandom,
            4'($urandom), $urandom_range(0, 1) == 1);
      checks++;
      if (ReadData !== m_read(adr) || done !== m_done || pass !== m_pass || addr_err !== m_err ||
          trc_overflow !== m_ovf || trc_valid !== (q.size() > 0) ||
          trc_addr !== head_a() || trc_data !== head_d())
        begin errors++;
          $display("FAIL rand_%0d got rd=%h d=%b p=%b e=%b o=%b v=%b h=%h/%h want rd=%h d=%b p=%b e=%b o=%b v=%b h=%h/%h",
                   i, ReadData, done, pass, addr_err, trc_overflow, trc_valid, trc_addr, trc_data,
                   m_read(adr), m_done, m_pass, m_err, m_ovf, q.size() > 0, head_a(), head_d());
        end
    end
    for (int i = 0; i < 2*TD && q.size() > 0; i++) cycle(0, 32'd0, 0, 0, 1);
    checks++;
    if (trc_valid !== 1'b0) begin errors++; $display("FAIL rand_empty got %b want 0", trc_valid); end
  endtask

  task automatic test_reset_mid();
    cycle(1, 32'd0, 32'h5A5A1234, 4'hF, 0);
    cycle(1, TOHOST, 32'd99, 4'hF, 0);
    cycle(1, 32'd8, $urandom, 4'hF, 0);
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL mid_pre_done got %b want 1", done); end
    if (trc_valid !== (q.size() > 0)) begin errors++; $display("FAIL mid_pre_valid got %b want %b", trc_valid, q.size() > 0); end
    #2 reset = 0;
    model_reset();
    #1;
    checks += 6;
    if (done !== 1'b0)         begin errors++; $display("FAIL mid_done got %b want 0", done); end
    if (pass !== 1'b0)         begin errors++; $display("FAIL mid_pass got %b want 0", pass); end
    if (addr_err !== 1'b0)     begin errors++; $display("FAIL mid_err got %b want 0", addr_err); end
    if (trc_overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf got %b want 0", trc_overflow); end
    if (trc_valid !== 1'b0)    begin errors++; $display("FAIL mid_valid got %b want 0", trc_valid); end
    if ({trc_addr, trc_data} !== 64'd0) begin errors++; $display("FAIL mid_head got %h want 0", {trc_addr, trc_data}); end
    MemWrite = 0; DataAdr = 32'd0;
    @(posedge clk);
    @(negedge clk) reset = 1;
    #1;
    checks++;
    if (ReadData !== 32'h5A5A1234) begin errors++; $display("FAIL mid_ram0 got %h want 5a5a1234", ReadData); end
  endtask

  initial begin
    test_reset();
    test_tohost_pass();
    test_tohost_fail();
    test_lane_merge();
    test_overflow();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
